// File: rtl/pipeline_pkg.sv
// -----------------------------------------------------------------------------
// pipeline_pkg
// Shared definitions for the MIPS pipeline hazard/stall control.
//   md_state_e          : mult/div tracker state (IDLE, MD_BUSY)
//   REG_ZERO            : architectural $zero register address
//   MD_LATENCY_DEFAULT  : default mult/div busy time after a start (cycles)
//   MD_CNT_W            : width of the mult/div remaining-cycles counter
// -----------------------------------------------------------------------------
package pipeline_pkg;

  typedef enum logic {
    IDLE    = 1'b0,
    MD_BUSY = 1'b1
  } md_state_e;

  localparam logic [4:0] REG_ZERO           = 5'd0;
  localparam int         MD_LATENCY_DEFAULT = 32;
  localparam int         MD_CNT_W           = 6;

endpackage : pipeline_pkg

// File: rtl/stall_controller_md_countdown.sv
// -----------------------------------------------------------------------------
// md_countdown
// Tracks the multi-cycle mult/div unit. A start in IDLE loads MD_LATENCY; the
// counter then decrements every cycle (stalled or not) and returns to IDLE on
// the edge where it reaches zero.
// Ports:
//   clk      in   pipeline clock
//   reset    in   asynchronous active-low reset
//   start    in   accepted mult/div start (only honoured in IDLE)
//   md_busy  out  unit busy (state == MD_BUSY)
//   md_count out  remaining busy cycles
// -----------------------------------------------------------------------------
module md_countdown
  import pipeline_pkg::*;
#(
  parameter int MD_LATENCY = MD_LATENCY_DEFAULT  // legal 2..63
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  output logic                md_busy,
  output logic [MD_CNT_W-1:0] md_count
);

  localparam logic [MD_CNT_W-1:0] LOAD_VAL = MD_CNT_W'(MD_LATENCY);

  md_state_e             state_q, state_d;
  logic [MD_CNT_W-1:0]   count_q, count_d;

  // NOTE: defaults first so every path assigns every output -- no latches.
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = MD_BUSY;
          count_d = LOAD_VAL;
        end
      end
      MD_BUSY: begin
        count_d = count_q - MD_CNT_W'(1);
        if (count_q == MD_CNT_W'(1)) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
        count_d = '0;
      end
    endcase
  end

  // NOTE: state registers use non-blocking assignments so all flops sample
  // their D inputs simultaneously at the edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
    end
  end

  assign md_busy  = (state_q == MD_BUSY);
  assign md_count = count_q;

endmodule : md_countdown

// File: rtl/stall_controller.sv
// -----------------------------------------------------------------------------
// stall_controller
// ID/EX hazard unit for the 5-stage MIPS pipeline. Produces hold/flush controls
// for the PC and pipeline registers from load-use hazards, mult/div busy
// hazards (HI/LO readers and back-to-back mult/div) and taken branches.
// A taken branch always wins: both wrong-path instructions are flushed and no
// hold is asserted that cycle.
//
// Optional build macro STALL_PERF_CNT_EN: when defined, stall_cycles counts
// stalled cycles (saturating, cleared by reset); otherwise it is tied to 0.
//
// Ports:
//   clk, reset (async active-low)
//   id_rs/id_rt, id_uses_rs/id_uses_rt : source operands of the ID instruction
//   ex_memread, ex_rt                  : load in EX and its destination
//   id_md_start, id_reads_hilo         : ID is mult/div, ID is mfhi/mflo
//   ex_branch_taken                    : redirect resolved in EX
//   pc_hold, ifid_hold, ifid_flush, idex_flush : pipeline controls
//   md_busy, md_count                  : mult/div unit status
//   stall_cycles                       : performance counter
// -----------------------------------------------------------------------------
module stall_controller
  import pipeline_pkg::*;
#(
  parameter int MD_LATENCY = MD_LATENCY_DEFAULT,
  parameter int RA_W       = 5
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [RA_W-1:0] id_rs,
  input  logic [RA_W-1:0] id_rt,
  input  logic            id_uses_rs,
  input  logic            id_uses_rt,
  input  logic            ex_memread,
  input  logic [RA_W-1:0] ex_rt,
  input  logic            id_md_start,
  input  logic            id_reads_hilo,
  input  logic            ex_branch_taken,
  output logic            pc_hold,
  output logic            ifid_hold,
  output logic            ifid_flush,
  output logic            idex_flush,
  output logic            md_busy,
  output logic [5:0]      md_count,
  output logic [31:0]     stall_cycles
);

  logic lu;
  logic mdh;
  logic stall;
  logic md_start_accept;

  // A load into $zero writes nothing, so it can never create a hazard.
  assign lu = ex_memread
            & (ex_rt != RA_W'(REG_ZERO))
            & ((id_uses_rs & (id_rs == ex_rt)) | (id_uses_rt & (id_rt == ex_rt)));

  assign mdh   = md_busy & (id_reads_hilo | id_md_start);
  assign stall = (lu | mdh) & ~ex_branch_taken;

  assign pc_hold    = stall;
  assign ifid_hold  = stall;
  assign ifid_flush = ex_branch_taken;
  assign idex_flush = stall | ex_branch_taken;

  // A mult/div only starts when it actually leaves ID this cycle.
  assign md_start_accept = id_md_start & ~stall & ~ex_branch_taken;

  md_countdown #(
    .MD_LATENCY (MD_LATENCY)
  ) u_md_countdown (
    .clk      (clk),
    .reset    (reset),
    .start    (md_start_accept),
    .md_busy  (md_busy),
    .md_count (md_count)
  );

`ifdef STALL_PERF_CNT_EN
  logic [31:0] stall_cycles_q, stall_cycles_d;

  always_comb begin
    stall_cycles_d = stall_cycles_q;
    if (stall && (stall_cycles_q != 32'hFFFF_FFFF)) begin
      stall_cycles_d = stall_cycles_q + 32'd1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_cycles_q <= 32'd0;
    end else begin
      stall_cycles_q <= stall_cycles_d;
    end
  end

  assign stall_cycles = stall_cycles_q;
`else
  assign stall_cycles = 32'd0;
`endif

endmodule : stall_controller

// File: tb/tb_stall_controller.sv
// -----------------------------------------------------------------------------
// tb_stall_controller
// Two instances share one stimulus stream: dut_a with MD_LATENCY=4 and dut_b
// with the default latency of 32. The driver pushes the expected outputs of
// both into a queue each cycle; the monitor pops and compares on the falling
// edge. The reference model tracks "cycles the unit remains busy" as a plain
// integer and the stall total as a plain count.
// -----------------------------------------------------------------------------
module tb_stall_controller;

  localparam int LAT_A = 4;
  localparam int LAT_B = 32;

`ifdef STALL_PERF_CNT_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  typedef struct packed {
    logic [4:0] rs;
    logic [4:0] rt;
    logic [4:0] ex_rt;
    logic       uses_rs;
    logic       uses_rt;
    logic       ex_memread;
    logic       md_start;
    logic       reads_hilo;
    logic       br;
  } stim_t;

  typedef struct packed {
    logic        pc_hold;
    logic        ifid_hold;
    logic        ifid_flush;
    logic        idex_flush;
    logic        md_busy;
    logic [5:0]  md_count;
    logic [31:0] stall_cycles;
  } outs_t;

  typedef struct packed {
    outs_t a;
    outs_t b;
  } pair_t;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  logic [4:0] id_rs, id_rt, ex_rt;
  logic       id_uses_rs, id_uses_rt, ex_memread, id_md_start, id_reads_hilo, ex_branch_taken;

  logic        pc_hold_a, ifid_hold_a, ifid_flush_a, idex_flush_a, md_busy_a;
  logic [5:0]  md_count_a;
  logic [31:0] stall_cycles_a;
  logic        pc_hold_b, ifid_hold_b, ifid_flush_b, idex_flush_b, md_busy_b;
  logic [5:0]  md_count_b;
  logic [31:0] stall_cycles_b;

  stall_controller #(.MD_LATENCY(LAT_A), .RA_W(5)) dut_a (
    .clk(clk), .reset(reset),
    .id_rs(id_rs), .id_rt(id_rt), .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
    .ex_memread(ex_memread), .ex_rt(ex_rt), .id_md_start(id_md_start),
    .id_reads_hilo(id_reads_hilo), .ex_branch_taken(ex_branch_taken),
    .pc_hold(pc_hold_a), .ifid_hold(ifid_hold_a), .ifid_flush(ifid_flush_a),
    .idex_flush(idex_flush_a), .md_busy(md_busy_a), .md_count(md_count_a),
    .stall_cycles(stall_cycles_a)
  );

  stall_controller #(.MD_LATENCY(LAT_B), .RA_W(5)) dut_b (
    .clk(clk), .reset(reset),
    .id_rs(id_rs), .id_rt(id_rt), .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
    .ex_memread(ex_memread), .ex_rt(ex_rt), .id_md_start(id_md_start),
    .id_reads_hilo(id_reads_hilo), .ex_branch_taken(ex_branch_taken),
    .pc_hold(pc_hold_b), .ifid_hold(ifid_hold_b), .ifid_flush(ifid_flush_b),
    .idex_flush(idex_flush_b), .md_busy(md_busy_b), .md_count(md_count_b),
    .stall_cycles(stall_cycles_b)
  );

  outs_t act_a, act_b;
  assign act_a = {pc_hold_a, ifid_hold_a, ifid_flush_a, idex_flush_a, md_busy_a, md_count_a, stall_cycles_a};
  assign act_b = {pc_hold_b, ifid_hold_b, ifid_flush_b, idex_flush_b, md_busy_b, md_count_b, stall_cycles_b};

  // Scoreboard and reference-model state.
  pair_t  exp_q[$];
  string  tag_q[$];
  int     rem_a, rem_b;      // cycles the unit will still be busy
  longint cnt_a, cnt_b;      // stalled cycles since reset
  int     n_tests = 0;
  int     n_fail  = 0;

  task automatic check(input string name, input outs_t got, input outs_t exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got ph=%0b ih=%0b if=%0b xf=%0b busy=%0b cnt=%0d sc=%0d, expected ph=%0b ih=%0b if=%0b xf=%0b busy=%0b cnt=%0d sc=%0d",
               name, got.pc_hold, got.ifid_hold, got.ifid_flush, got.idex_flush, got.md_busy,
               got.md_count, got.stall_cycles, exp.pc_hold, exp.ifid_hold, exp.ifid_flush,
               exp.idex_flush, exp.md_busy, exp.md_count, exp.stall_cycles);
    end
  endtask

  task automatic report_timeout(input string name);
    n_tests++;
    n_fail++;
    $display("FAIL %s: bound expired before expected condition", name);
  endtask

  // Would the ID instruction be held back this cycle, given how long the unit
  // is still busy?
  function automatic bit stalls(input stim_t s, input int busy_left);
    bit load_use, md_hazard;
    load_use  = s.ex_memread && (s.ex_rt != 5'd0) &&
                ((s.uses_rs && s.rs == s.ex_rt) || (s.uses_rt && s.rt == s.ex_rt));
    md_hazard = (busy_left > 0) && (s.reads_hilo || s.md_start);
    return (load_use || md_hazard) && !s.br;
  endfunction

  function automatic outs_t expect_outs(input stim_t s, input int busy_left, input longint stalled);
    outs_t o;
    bit    st;
    st             = stalls(s, busy_left);
    o.pc_hold      = st;
    o.ifid_hold    = st;
    o.ifid_flush   = s.br;
    o.idex_flush   = st || s.br;
    o.md_busy      = (busy_left > 0);
    o.md_count     = 6'(busy_left);
    o.stall_cycles = PERF ? 32'(stalled) : 32'd0;
    return o;
  endfunction

  function automatic int next_busy(input stim_t s, input int busy_left, input int lat);
    if (busy_left > 0) return busy_left - 1;
    if (s.md_start && !stalls(s, busy_left) && !s.br) return lat;
    return 0;
  endfunction

  function automatic longint next_stalled(input stim_t s, input int busy_left, input longint stalled);
    if (stalls(s, busy_left) && stalled < 64'h0000_0000_FFFF_FFFF) return stalled + 1;
    return stalled;
  endfunction

  task automatic apply(input stim_t s);
    id_rs           = s.rs;
    id_rt           = s.rt;
    ex_rt           = s.ex_rt;
    id_uses_rs      = s.uses_rs;
    id_uses_rt      = s.uses_rt;
    ex_memread      = s.ex_memread;
    id_md_start     = s.md_start;
    id_reads_hilo   = s.reads_hilo;
    ex_branch_taken = s.br;
  endtask

  task automatic push_expect(input stim_t s, input string tag);
    pair_t e;
    e.a = expect_outs(s, rem_a, cnt_a);
    e.b = expect_outs(s, rem_b, cnt_b);
    exp_q.push_back(e);
    tag_q.push_back(tag);
  endtask

  // One pipeline cycle: drive just after the edge, record the expectation,
  // optionally release reset mid-cycle, then advance the model to the next edge.
  task automatic drive(input stim_t s, input string tag, input bit release_rst = 1'b0);
    int     na, nb;
    longint ca, cb;
    @(posedge clk);
    #1;
    apply(s);
    push_expect(s, tag);
    if (release_rst) begin
      #2;
      reset = 1'b1;
    end
    if (reset) begin
      na = next_busy(s, rem_a, LAT_A);
      nb = next_busy(s, rem_b, LAT_B);
      ca = next_stalled(s, rem_a, cnt_a);
      cb = next_stalled(s, rem_b, cnt_b);
      rem_a = na; rem_b = nb; cnt_a = ca; cnt_b = cb;
    end
  endtask

  task automatic wait_idle(input string name);
    stim_t nop;
    nop = '0;
    for (int k = 0; k < 40 && (rem_a != 0 || rem_b != 0); k++) drive(nop, name);
    if (rem_a != 0 || rem_b != 0) report_timeout(name);
  endtask

  function automatic stim_t rand_stim();
    stim_t s;
    s.rs         = 5'($urandom_range(0, 3));
    s.rt         = 5'($urandom_range(0, 3));
    s.ex_rt      = 5'($urandom_range(0, 3));
    s.uses_rs    = 1'($urandom_range(0, 1));
    s.uses_rt    = 1'($urandom_range(0, 1));
    s.ex_memread = 1'($urandom_range(0, 1));
    s.md_start   = ($urandom_range(0, 7) == 0);
    s.reads_hilo = ($urandom_range(0, 3) == 0);
    s.br         = ($urandom_range(0, 9) == 0);
    return s;
  endfunction

  // Monitor: outputs are valid every cycle, compared on the falling edge.
  initial begin
    forever begin
      @(negedge clk);
      if (exp_q.size() != 0) begin
        pair_t e;
        string t;
        e = exp_q.pop_front();
        t = tag_q.pop_front();
        check({t, " [lat4]"},  act_a, e.a);
        check({t, " [lat32]"}, act_b, e.b);
      end
    end
  end

  initial begin
    stim_t nop, s;
    nop   = '0;
    rem_a = 0; rem_b = 0; cnt_a = 0; cnt_b = 0;
    apply(nop);

    // Reset state, then release between edges.
    drive(nop, "reset state");
    drive(nop, "reset release", 1'b1);
    drive(nop, "idle after reset");

    // Load-use stall for exactly one cycle.
    s = nop; s.ex_memread = 1'b1; s.ex_rt = 5'd8; s.rs = 5'd8; s.uses_rs = 1'b1;
    drive(s, "load-use rs");
    drive(nop, "load-use drop");
    s = nop; s.ex_memread = 1'b1; s.ex_rt = 5'd9; s.rt = 5'd9; s.uses_rt = 1'b1; s.rs = 5'd9;
    drive(s, "load-use rt");
    s.uses_rt = 1'b0;
    drive(s, "match but operand unused");

    // No false stall on $zero.
    s = nop; s.ex_memread = 1'b1; s.uses_rs = 1'b1;
    drive(s, "zero reg no stall");

    // Mult/div countdown with a held HI/LO reader.
    s = nop; s.md_start = 1'b1;
    drive(s, "md start");
    s = nop; s.reads_hilo = 1'b1;
    for (int k = 0; k < 6; k++) drive(s, "hilo during countdown");
    wait_idle("idle wait 1");

    // Back-to-back mult/div on the short unit.
    s = nop; s.md_start = 1'b1;
    for (int k = 0; k < 7; k++) drive(s, "back-to-back md");
    wait_idle("idle wait 2");

    // Branch priority over load-use and over a mult/div start.
    s = nop; s.ex_memread = 1'b1; s.ex_rt = 5'd8; s.rs = 5'd8; s.uses_rs = 1'b1;
    s.md_start = 1'b1; s.br = 1'b1;
    drive(s, "branch priority");
    drive(nop, "no md after branch");

    // Branch while busy: countdown continues.
    s = nop; s.md_start = 1'b1;
    drive(s, "md start 2");
    s = nop; s.br = 1'b1; s.reads_hilo = 1'b1;
    drive(s, "branch while busy");
    drive(nop, "busy after branch");

    // Randomized traffic.
    for (int k = 0; k < 2000; k++) drive(rand_stim(), "random");

    // Reset in the middle of the long countdown at md_count = 17.
    wait_idle("idle wait 3");
    s = nop; s.md_start = 1'b1;
    drive(s, "md start long");
    for (int k = 0; k < 64 && rem_b != 17; k++) drive(nop, "countdown to 17");
    if (rem_b != 17) report_timeout("reach count 17");
    s = nop; s.reads_hilo = 1'b1;
    @(posedge clk);
    #1;
    apply(s);
    #2;
    reset = 1'b0;
    rem_a = 0; rem_b = 0; cnt_a = 0; cnt_b = 0;
    push_expect(s, "async reset immediate");
    drive(s, "reset held", 1'b1);
    drive(s, "post-reset hilo no stall");

    // Stall counter: one load-use stall plus a mult/div hazard run.
    s = nop; s.ex_memread = 1'b1; s.ex_rt = 5'd8; s.rs = 5'd8; s.uses_rs = 1'b1;
    drive(s, "perf load-use");
    drive(nop, "perf gap");
    s = nop; s.md_start = 1'b1;
    drive(s, "perf md start");
    s = nop; s.reads_hilo = 1'b1;
    for (int k = 0; k < 6; k++) drive(s, "perf mdh");
    drive(nop, "perf final");

    // Drain the scoreboard.
    for (int k = 0; k < 10 && exp_q.size() != 0; k++) @(negedge clk);
    if (exp_q.size() != 0) report_timeout("scoreboard drain");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule : tb_stall_controller

// File: doc/stall_controller.md
Name: stall_controller

Overview:
- Generates the hold and flush controls consumed by the PC and pipeline registers (hold = 1 freezes the register, 0 loads D).
- Detects load-use hazards and branch-taken redirects.
- Tracks the multi-cycle mult/div unit, stalling HI/LO consumers and back-to-back mult/div until the unit completes.
- Sits between the ID and EX stages of the 5-stage MIPS pipeline.

Parameters:
- MD_LATENCY, 32: cycles the mult/div unit is busy after a start; legal range 2..63.
- RA_W, 5: register address width.

Ports:
- clk  input  1  pipeline clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-low reset.
- id_rs  input  RA_W  rs field of the instruction in ID.
- id_rt  input  RA_W  rt field of the instruction in ID.
- id_uses_rs  input  1  the ID instruction reads rs.
- id_uses_rt  input  1  the ID instruction reads rt.
- ex_memread  input  1  the EX instruction is a load.
- ex_rt  input  RA_W  destination of the load in EX.
- id_md_start  input  1  the ID instruction is mult/multu/div/divu.
- id_reads_hilo  input  1  the ID instruction is mfhi/mflo.
- ex_branch_taken  input  1  branch/jump resolved taken in EX.
- pc_hold  output  1  hold the PC register.
- ifid_hold  output  1  hold the IF/ID register.
- ifid_flush  output  1  load a NOP into IF/ID.
- idex_flush  output  1  load a bubble into ID/EX.
- md_busy  output  1  mult/div unit is busy.
- md_count  output  6  remaining busy cycles.
- stall_cycles  output  32  stall cycle count (see Optional Feature).

Behaviour:
- Reset (reset = 0, asynchronous):
  - state = IDLE, md_count = 0, md_busy = 0, stall_cycles = 0.
  - Combinational outputs evaluate with IDLE state, so all holds and flushes follow the inputs.
  - Reset mid-countdown abandons the operation; there is no pending stall after release.
- Hazard terms (combinational, same cycle):
  - lu = ex_memread & (ex_rt != 0) & ((id_uses_rs & id_rs == ex_rt) | (id_uses_rt & id_rt == ex_rt))
  - mdh = md_busy & (id_reads_hilo | id_md_start)
  - stall = (lu | mdh) & ~ex_branch_taken
- Outputs:
  - pc_hold = ifid_hold = stall.
  - idex_flush = stall | ex_branch_taken.
  - ifid_flush = ex_branch_taken.
- Priority:
  - A branch taken kills both wrong-path instructions (IF and ID).
  - It overrides any stall; the hold outputs are 0 that cycle.
- FSM states: IDLE, MD_BUSY.
  - IDLE -> MD_BUSY when id_md_start & ~stall & ~ex_branch_taken. On that edge, md_count <= MD_LATENCY.
  - MD_BUSY: md_count decrements by 1 every cycle, including stall cycles.
  - MD_BUSY -> IDLE when md_count == 1 at the edge; md_count becomes 0.
  - md_busy = (state == MD_BUSY).
- A new mult/div in ID while busy stalls (mdh). It is accepted on the first cycle md_busy = 0, which gives exactly MD_LATENCY + 1 cycles between back-to-back starts.
- mfhi/mflo reaches EX no earlier than the cycle after md_busy falls.
- Load-use stalls last exactly one cycle: the bubble moves the load to MEM, and lu drops.
- Simultaneous lu and mdh: a single stall; the counter still decrements.
- ex_branch_taken while MD_BUSY: the countdown continues. The unit's in-flight operation is architecturally committed.
- No latency beyond the registered md_count; hazard outputs are purely combinational from the inputs and state.

Optional Feature:
- Macro: STALL_PERF_CNT_EN.
- Defined:
  - stall_cycles increments by 1 on every rising edge where stall = 1.
  - Saturates at 32'hFFFFFFFF; cleared only by reset.
- Undefined:
  - No counter logic is generated; stall_cycles is tied to 32'd0.
  - The port remains for a stable interface.

Decomposition:
- Shared package pipeline_pkg:
  - State enum {IDLE, MD_BUSY}.
  - REG_ZERO = 5'd0.
  - Default MD_LATENCY constant.
  - Width constant for md_count.
- Sub-module md_countdown holds the load/decrement counter and generates md_busy.
- stall_controller instantiates md_countdown and adds the hazard logic and the optional counter.

Test Plan:
- Load-use stall:
  - Stimulus: ex_memread=1, ex_rt=8, id_rs=8, id_uses_rs=1.
  - Response: pc_hold=ifid_hold=idex_flush=1 for one cycle. With ex_memread dropped next cycle, all outputs are 0.
- No false stall on $zero:
  - Stimulus: ex_memread=1, ex_rt=0, id_rs=0, id_uses_rs=1.
  - Response: all holds 0.
- Mult/div countdown:
  - Stimulus: MD_LATENCY=4; id_md_start=1 for one cycle, then id_reads_hilo=1 held.
  - Response: md_count runs 4,3,2,1,0; holds=1 for the 4 busy cycles, then 0.
- Branch priority:
  - Stimulus: ex_branch_taken=1 together with a load-use match.
  - Response: pc_hold=0, ifid_flush=1, idex_flush=1. A simultaneous id_md_start does not start the countdown (md_busy stays 0).
- Reset mid-operation:
  - Stimulus: assert reset=0 asynchronously at md_count=17, between edges.
  - Response: md_busy=0 and md_count=0 immediately. After release, id_reads_hilo causes no stall.
- STALL_PERF_CNT_EN:
  - Stimulus: the load-use case plus a 4-cycle mdh stall.
  - Response: stall_cycles=5 with the macro defined; stall_cycles=0 without it.
